attn_inst_sequencer: RTL

- Master controller that generates the 20-bit `inst` word driving the attention core datapath: Q/K SRAMs, MAC array, output FIFO, psum SRAM and SFP row.
- On `start` it runs one full pass in order: K load, Q load, kernel load into the array, execute, FIFO drain to psum memory, then optional two-step softmax-style normalization (acc, then div) per psum row.
- Replaces hand-written testbench instruction streams for this pass.

---
 rtl/attn_inst_sequencer_if.sv | 24 ++
 rtl/attn_inst_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/attn_inst_sequencer_if.sv
// Handshake and instruction bus between the attention instruction sequencer
// and its environment (host loader, output FIFO status, core instruction port).
interface attn_inst_sequencer_if;
  logic        start;
  logic        norm_en;
  logic        in_valid;
  logic        in_ready;
  logic        fifo_valid;
  logic [19:0] inst;
  logic        busy;
  logic        done;

  // Sequencer side
  modport master (
    input  start, norm_en, in_valid, fifo_valid,
    output in_ready, inst, busy, done
  );

  // Host / core side
  modport slave (
    output start, norm_en, in_valid, fifo_valid,
    input  in_ready, inst, busy, done
  );
endinterface

// File: rtl/attn_inst_sequencer.sv
// Attention core instruction sequencer: one pass of K load, Q load, kernel
// load, execute, FIFO drain and optional per-row normalization.
// All outputs come from registers. The only exception is the data-handshake
// strobes (kmem_wr/qmem_wr during loads, ofifo_rd/pmem_wr during drain): a
// registered enable is ANDed with the live valid so the write lands in the
// same cycle the word or FIFO entry is actually present.
module attn_inst_sequencer #(
  parameter int col    = 8,
  parameter int nq     = 8,
  parameter int addr_w = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  attn_inst_sequencer_if.master  bus
);

  localparam int CW = addr_w + 1;
  localparam logic [CW-1:0] ZERO     = {CW{1'b0}};
  localparam logic [CW-1:0] ONE      = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] COL_LAST = CW'(col - 1);
  localparam logic [CW-1:0] COL_END  = CW'(col);
  localparam logic [CW-1:0] NQ_LAST  = CW'(nq - 1);
  localparam logic [CW-1:0] NQ_END   = CW'(nq);

  typedef enum logic [2:0] {
    IDLE, LOAD_K, LOAD_Q, KLOAD, EXEC, DRAIN, NORM, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      sub_q, sub_d;
  logic            norm_q, norm_d;
  logic [19:0]     inst_q, inst_d;
  logic            karm_q, karm_d;
  logic            qarm_q, qarm_d;
  logic            darm_q, darm_d;
  logic            rdy_q, rdy_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Next-state, counter and captured-mode logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    norm_d  = norm_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD_K;
          cnt_d   = ZERO;
          sub_d   = 2'd0;
          norm_d  = bus.norm_en;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_K: begin
        if (bus.in_valid) begin
          if (cnt_q == COL_LAST) begin
            state_d = LOAD_Q;
            cnt_d   = ZERO;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      LOAD_Q: begin
        if (bus.in_valid) begin
          if (cnt_q == NQ_LAST) begin
            state_d = KLOAD;
            cnt_d   = ZERO;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      KLOAD: begin
        if (cnt_q == COL_END) begin
          state_d = EXEC;
          cnt_d   = ZERO;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      EXEC: begin
        if (cnt_q == NQ_END) begin
          state_d = DRAIN;
          cnt_d   = ZERO;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      DRAIN: begin
        if (bus.fifo_valid) begin
          if (cnt_q == NQ_LAST) begin
            state_d = norm_q ? NORM : DONE;
            cnt_d   = ZERO;
            sub_d   = 2'd0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      NORM: begin
        sub_d = sub_q + 2'd1;
        if (sub_q == 2'd3) begin
          if (cnt_q == NQ_LAST) begin
            state_d = DONE;
            cnt_d   = ZERO;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = ZERO;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = ZERO;
        sub_d   = 2'd0;
      end
    endcase
  end

  // Decode the instruction word for the upcoming cycle from the next state
  always_comb begin
    inst_d = 20'd0;
    karm_d = 1'b0;
    qarm_d = 1'b0;
    darm_d = 1'b0;
    rdy_d  = 1'b0;
    busy_d = (state_d != IDLE);
    done_d = 1'b0;
    case (state_d)
      LOAD_K: begin
        rdy_d          = 1'b1;
        karm_d         = 1'b1;
        inst_d[15:12]  = 4'(cnt_d);
      end
      LOAD_Q: begin
        rdy_d          = 1'b1;
        qarm_d         = 1'b1;
        inst_d[15:12]  = 4'(cnt_d);
      end
      KLOAD: begin
        // Array kernel-load strobe trails the K read by one cycle (SRAM latency)
        if (cnt_d < COL_END) begin
          inst_d[3]     = 1'b1;
          inst_d[15:12] = 4'(cnt_d);
        end else begin
          inst_d[3]     = 1'b0;
        end
        inst_d[6] = (cnt_d != ZERO);
      end
      EXEC: begin
        // Execute strobe trails the Q read by one cycle (SRAM latency)
        if (cnt_d < NQ_END) begin
          inst_d[5]     = 1'b1;
          inst_d[15:12] = 4'(cnt_d);
        end else begin
          inst_d[5]     = 1'b0;
        end
        inst_d[7] = (cnt_d != ZERO);
      end
      DRAIN: begin
        darm_d        = 1'b1;
        inst_d[11:8]  = 4'(cnt_d);
      end
      NORM: begin
        inst_d[11:8] = 4'(cnt_d);
        case (sub_d)
          2'd0:    inst_d[1]  = 1'b1;
          2'd1:    inst_d[17] = 1'b1;
          2'd2:    inst_d[1]  = 1'b1;
          2'd3: begin
            inst_d[18] = 1'b1;
            inst_d[0]  = 1'b1;
          end
          default: inst_d[1]  = 1'b0;
        endcase
      end
      DONE:    done_d = 1'b1;
      default: done_d = 1'b0;
    endcase
  end

  // FSM state, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= ZERO;
      sub_q   <= 2'd0;
      norm_q  <= 1'b0;
      inst_q  <= 20'd0;
      karm_q  <= 1'b0;
      qarm_q  <= 1'b0;
      darm_q  <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      norm_q  <= norm_d;
      inst_q  <= inst_d;
      karm_q  <= karm_d;
      qarm_q  <= qarm_d;
      darm_q  <= darm_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.inst = {inst_q[19:17],
                     inst_q[16] | (darm_q & bus.fifo_valid),
                     inst_q[15:5],
                     inst_q[4]  | (qarm_q & bus.in_valid),
                     inst_q[3],
                     inst_q[2]  | (karm_q & bus.in_valid),
                     inst_q[1],
                     inst_q[0]  | (darm_q & bus.fifo_valid)};
  assign bus.in_ready = rdy_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
